davinci_dataout_reader: RTL

- Host-side consumer of the DA-VinCi FIFO-out stream.
- Pops 16-bit vector elements and their attributes from a first-word-fall-through FIFO and packs pairs of elements into 32-bit host words on a valid/ready stream.
- Detects end-of-vector (EOV) and reports the vector length.
- Acknowledges the DA-VinCi EOV interrupt by driving clearEOV after the vector's last word has been delivered.

---
 rtl/davinci_dataout_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/davinci_dataout_reader.sv
// Host-side reader for the DA-VinCi FIFO-out stream: packs element pairs into
// host words, reports vector length on EOV and acknowledges the EOV interrupt.
`timescale 1ns/1ps
module davinci_dataout_reader #(
  parameter int DATAOUT_WIDTH = 16,
  parameter int ATTRIB_WIDTH  = 2,
  parameter int EOV_BIT       = 0,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATAOUT_WIDTH-1:0]   fifoData,
  input  logic [ATTRIB_WIDTH-1:0]    fifoAttrib,
  input  logic                       fifoEmpty,
  output logic                       fifoRdEn,
  input  logic                       eovInterrupt,
  output logic                       clearEOV,
  output logic [2*DATAOUT_WIDTH-1:0] hostData,
  output logic [1:0]                 hostKeep,
  output logic                       hostLast,
  output logic                       hostValid,
  input  logic                       hostReady,
  output logic [LEN_WIDTH-1:0]       vecLen,
  output logic                       vecDone
);

  typedef enum logic [1:0] {LO, HI, OUT, CLR} state_t;

  state_t                     state_q, state_d;
  logic [2*DATAOUT_WIDTH-1:0] data_q, data_d;
  logic [1:0]                 keep_q, keep_d;
  logic                       last_q, last_d;
  logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]       vec_len_q, vec_len_d;
  logic                       vec_done_q, vec_done_d;

  logic can_pop;
  logic pop;
  logic elem_eov;
  logic lo_cap;
  logic clear_eov;
  logic attrib_unused;

  assign can_pop  = (state_q == LO) || (state_q == HI) ||
                    ((state_q == OUT) && hostReady && !last_q);
  assign pop      = !fifoEmpty && can_pop;
  assign elem_eov = fifoAttrib[EOV_BIT];
  // Only the EOV bit carries meaning; the remaining attribute bits are dropped.
  assign attrib_unused = ^fifoAttrib;

  // A pop in OUT implies the current word was accepted, so it starts a new low half.
  assign lo_cap = pop && ((state_q == LO) || (state_q == OUT));

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    keep_d     = keep_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    vec_len_d  = vec_len_q;
    vec_done_d = 1'b0;
    clear_eov  = 1'b0;

    case (state_q)
      LO: ;
      HI: begin
        if (pop) begin
          data_d[2*DATAOUT_WIDTH-1 -: DATAOUT_WIDTH] = fifoData;
          keep_d  = 2'b11;
          last_d  = elem_eov;
          state_d = OUT;
        end
      end
      OUT: begin
        if (hostReady) begin
          if (last_q) begin
            state_d = CLR;
          end else if (!pop) begin
            state_d = LO;
          end
        end
      end
      CLR: begin
        clear_eov = eovInterrupt;
        if (!eovInterrupt) begin
          state_d = LO;
        end
      end
      default: state_d = LO;
    endcase

    if (lo_cap) begin
      data_d  = {{DATAOUT_WIDTH{1'b0}}, fifoData};
      keep_d  = 2'b01;
      last_d  = elem_eov;
      state_d = elem_eov ? OUT : HI;
    end

    if (pop) begin
      if (elem_eov) begin
        vec_len_d  = cnt_q + 1'b1;
        vec_done_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= LO;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      vec_len_q  <= '0;
      vec_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      vec_len_q  <= vec_len_d;
      vec_done_q <= vec_done_d;
    end
  end

  assign fifoRdEn  = pop;
  assign clearEOV  = clear_eov;
  assign hostData  = data_q;
  assign hostKeep  = keep_q;
  assign hostLast  = last_q;
  assign hostValid = (state_q == OUT);
  assign vecLen    = vec_len_q;
  assign vecDone   = vec_done_q;

endmodule
